fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 43 ++++
 rtl/fb_arbiter_if.sv | 40 ++++
 rtl/fb_wr_fifo.sv | 60 ++++++
 rtl/fb_arbiter.sv | 108 ++++++++++
 tb/tb_fb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Brief    : Shared framebuffer constants, state encoding, write-request type.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 8;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DISP = 2'd1,
        S_WR   = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [ROW_W-1:0]   row;
        logic [COL_W-1:0]   col;
        logic [COLOR_W-1:0] color;
    } wr_req_t;

    // row*640 as two shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 9) + (r << 7) + ADDR_W'(col);
    endfunction

    function automatic logic fb_in_screen(input logic [ROW_W-1:0] row,
                                          input logic [COL_W-1:0] col);
        return (row < ROW_W'(SCREEN_H)) && (col < COL_W'(SCREEN_W));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_arbiter_if
// Brief    : VGA timing, writer handshake and SRAM bus bundle of fb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface fb_arbiter_if;
    import fb_pkg::*;

    logic                pix_phase;
    logic [ROW_W-1:0]    vga_row;
    logic [COL_W-1:0]    vga_col;
    logic                vga_blank;
    logic                wr_valid;
    logic                wr_ready;
    logic [ROW_W-1:0]    wr_row;
    logic [COL_W-1:0]    wr_col;
    logic [COLOR_W-1:0]  wr_color;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [COLOR_W-1:0]  mem_wdata;
    logic [COLOR_W-1:0]  mem_rdata;
    logic [COLOR_W-1:0]  pixel_color;
    logic                pixel_valid;

    modport master (
        input  pix_phase, vga_row, vga_col, vga_blank,
        input  wr_valid, wr_row, wr_col, wr_color, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata, pixel_color, pixel_valid
    );

    modport slave (
        output pix_phase, vga_row, vga_col, vga_blank,
        output wr_valid, wr_row, wr_col, wr_color, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata, pixel_color, pixel_valid
    );

endinterface
`default_nettype wire

// File: rtl/fb_wr_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_wr_fifo
// Brief    : Power-of-two deep FIFO of pending pixel write requests.
// Revision : 1.0 - initial release
// ============================================================================
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    push_i,
    input  wr_req_t req_i,
    input  logic    pop_i,
    output wr_req_t req_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    wr_req_t        mem_q [FIFO_DEPTH];
    logic [PTR_W:0] wptr_q;
    logic [PTR_W:0] rptr_q;
    logic           do_push;
    logic           do_pop;

    // extra pointer MSB distinguishes full from empty when the indices match
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign req_o   = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[PTR_W-1:0]] <= req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (PTR_W+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_arbiter
// Brief    : Shares one framebuffer SRAM between VGA display fetches and
//            queued pixel writes, one memory slot per clock.
// Revision : 1.0 - initial release
// ============================================================================
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    fb_arbiter_if.master bus
);

    wr_req_t              req_in;
    wr_req_t              head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 sel_disp;
    logic                 head_ok;

    fb_state_e            state_q;
    fb_state_e            state_d;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic                 mem_we_q;
    logic                 mem_we_d;
    logic [COLOR_W-1:0]   mem_wdata_q;
    logic [COLOR_W-1:0]   mem_wdata_d;
    logic                 disp2_q;
    logic                 pixel_valid_q;
    logic [COLOR_W-1:0]   pixel_color_q;

    assign req_in       = '{row: bus.wr_row, col: bus.wr_col, color: bus.wr_color};
    // full is registered state, so ready never sees the same-cycle pop
    assign bus.wr_ready = reset && !full;
    assign push         = bus.wr_valid && bus.wr_ready;
    assign sel_disp     = !bus.vga_blank && !bus.pix_phase;
    assign pop          = !sel_disp && !empty;
    assign head_ok      = fb_in_screen(head.row, head.col);

    fb_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_n_i (reset),
        .push_i  (push),
        .req_i   (req_in),
        .pop_i   (pop),
        .req_o   (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d     = S_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (sel_disp) begin
            state_d    = S_DISP;
            mem_addr_d = fb_addr(bus.vga_row, bus.vga_col);
        end else if (pop && head_ok) begin
            // off-screen heads are still popped but leave the bus idle
            state_d     = S_WR;
            mem_addr_d  = fb_addr(head.row, head.col);
            mem_wdata_d = head.color;
            mem_we_d    = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            disp2_q       <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_color_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            // read data arrives the cycle after the address is on the bus
            disp2_q       <= (state_q == S_DISP);
            pixel_valid_q <= disp2_q;
            if (disp2_q) begin
                pixel_color_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.pixel_color = pixel_color_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_arbiter
// Brief    : Self-checking bench for fb_arbiter against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

    localparam int DEPTH = 4;
    localparam int HIST  = 8;

    typedef struct packed {
        logic [8:0] row;
        logic [9:0] col;
        logic [7:0] color;
    } wreq_t;

    typedef struct packed {
        logic        wr;
        logic [8:0]  row;
        logic [9:0]  col;
        logic [7:0]  color;
        logic [7:0]  rdata;
        logic [18:0] exp_addr;
        logic        exp_we;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    fb_arbiter_if bus ();

    fb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic       s_rst, s_blank, s_phase, s_wv;
    logic [8:0] s_vrow, s_wrow;
    logic [9:0] s_vcol, s_wcol;
    logic [7:0] s_wcolor, s_rdata;

    wreq_t       q[$];
    int          pix_due[$];
    logic [7:0]  rd_hist [HIST];
    logic [18:0] m_addr  = '0;
    logic        m_we    = 1'b0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_pc    = '0;
    logic        m_ready = 1'b0;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check();
        logic pv_exp;
        rd_hist[cyc % HIST] = s_rdata;
        if (!rst_n) begin
            q.delete();
            pix_due.delete();
            m_addr = '0; m_we = 1'b0; m_wdata = '0; m_pc = '0;
        end
        pv_exp = 1'b0;
        if (rst_n && pix_due.size() != 0 && pix_due[0] == cyc) begin
            void'(pix_due.pop_front());
            pv_exp = 1'b1;
            m_pc   = rd_hist[(cyc - 1) % HIST];
        end
        m_ready = rst_n && (q.size() < DEPTH);
        chk("wr_ready",    bus.wr_ready,    m_ready);
        chk("mem_we",      bus.mem_we,      m_we);
        chk("mem_addr",    bus.mem_addr,    m_addr);
        chk("mem_wdata",   bus.mem_wdata,   m_wdata);
        chk("pixel_valid", bus.pixel_valid, pv_exp);
        chk("pixel_color", bus.pixel_color, m_pc);
    endtask

    // one slot decision per cycle, computed from the arbitration rules
    task automatic model_step();
        wreq_t w;
        if (!rst_n) return;
        m_we = 1'b0;
        if (!s_blank && !s_phase) begin
            m_addr = 19'(int'(s_vrow) * 640 + int'(s_vcol));
            pix_due.push_back(cyc + 3);
        end else if (q.size() != 0) begin
            w = q.pop_front();
            if (int'(w.row) < 480 && int'(w.col) < 640) begin
                m_we    = 1'b1;
                m_addr  = 19'(int'(w.row) * 640 + int'(w.col));
                m_wdata = w.color;
            end
        end
        if (s_wv && m_ready) begin
            w.row = s_wrow; w.col = s_wcol; w.color = s_wcolor;
            q.push_back(w);
        end
    endtask

    // applies staged inputs just after the edge, checks at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rst_n         = s_rst;
        bus.vga_blank = s_blank;
        bus.pix_phase = s_phase;
        bus.vga_row   = s_vrow;
        bus.vga_col   = s_vcol;
        bus.wr_valid  = s_wv;
        bus.wr_row    = s_wrow;
        bus.wr_col    = s_wcol;
        bus.wr_color  = s_wcolor;
        bus.mem_rdata = s_rdata;
        #9;
        model_check();
        model_step();
    endtask

    task automatic idle(input int n);
        s_blank = 1'b1; s_phase = 1'b1; s_wv = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, issued, nwe, pcnt;
        logic prev_phase;

        vt[0] = '{1'b1, 9'd2,   10'd5,    8'hA5, 8'h00, 19'd1285,   1'b1};
        vt[1] = '{1'b1, 9'd0,   10'd0,    8'h11, 8'h00, 19'd0,      1'b1};
        vt[2] = '{1'b1, 9'd479, 10'd639,  8'hFF, 8'h00, 19'd307199, 1'b1};
        vt[3] = '{1'b1, 9'd480, 10'd0,    8'h22, 8'h00, 19'd0,      1'b0};
        vt[4] = '{1'b1, 9'd0,   10'd640,  8'h33, 8'h00, 19'd0,      1'b0};
        vt[5] = '{1'b1, 9'd511, 10'd1023, 8'h44, 8'h00, 19'd0,      1'b0};
        vt[6] = '{1'b1, 9'd300, 10'd17,   8'h7E, 8'h00, 19'd192017, 1'b1};
        vt[7] = '{1'b0, 9'd1,   10'd3,    8'h00, 8'h3C, 19'd643,    1'b0};
        vt[8] = '{1'b0, 9'd479, 10'd639,  8'h00, 8'h5A, 19'd307199, 1'b0};
        vt[9] = '{1'b0, 9'd100, 10'd200,  8'h00, 8'hC3, 19'd64200,  1'b0};

        for (int k = 0; k < HIST; k++) rd_hist[k] = '0;
        s_rst = 1'b0; s_blank = 1'b1; s_phase = 1'b1; s_wv = 1'b0;
        s_vrow = '0; s_vcol = '0; s_wrow = '0; s_wcol = '0; s_wcolor = '0; s_rdata = '0;
        rst_n = 1'b0;
        bus.vga_blank = 1'b1; bus.pix_phase = 1'b1; bus.vga_row = '0; bus.vga_col = '0;
        bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_color = '0;
        bus.mem_rdata = '0;

        // reset values, then ready on the first cycle after release
        for (int k = 0; k < 3; k++) tick();
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        s_rst = 1'b1;
        tick();
        chk("release_wr_ready", bus.wr_ready, 1'b1);

        // directed vector table
        for (int i = 0; i < 10; i++) begin
            idle(2);
            if (vt[i].wr) begin
                s_wv = 1'b1; s_wrow = vt[i].row; s_wcol = vt[i].col; s_wcolor = vt[i].color;
                tick();
                s_wv = 1'b0;
                tick();
                tick();
                chk("tbl_we", bus.mem_we, vt[i].exp_we);
                if (vt[i].exp_we) begin
                    chk("tbl_waddr", bus.mem_addr, vt[i].exp_addr);
                    chk("tbl_wdata", bus.mem_wdata, vt[i].color);
                end
            end else begin
                s_blank = 1'b0; s_phase = 1'b0; s_vrow = vt[i].row; s_vcol = vt[i].col;
                tick();
                s_blank = 1'b1; s_phase = 1'b1;
                tick();
                chk("tbl_raddr", bus.mem_addr, vt[i].exp_addr);
                chk("tbl_rwe", bus.mem_we, 1'b0);
                s_rdata = vt[i].rdata;
                tick();
                s_rdata = 8'h00;
                tick();
                chk("tbl_pvalid", bus.pixel_valid, 1'b1);
                chk("tbl_pcolor", bus.pixel_color, vt[i].rdata);
            end
        end

        // five back-to-back writes during active video into a 4-deep FIFO
        idle(2);
        s_blank = 1'b0; idx = 0; issued = 0; prev_phase = 1'b0;
        for (int t = 0; t < 30; t++) begin
            s_phase  = (t < 6) ? 1'b0 : 1'(t & 1);
            s_vrow   = 9'd20; s_vcol = 10'(t);
            s_wv     = (idx < 5);
            s_wrow   = 9'd10; s_wcol = 10'(idx + 1); s_wcolor = 8'(8'h40 + idx);
            tick();
            if (t == 4) chk("full_wr_ready", bus.wr_ready, 1'b0);
            if (bus.mem_we === 1'b1) begin
                chk("seq_addr", bus.mem_addr, 19'(6400 + issued + 1));
                chk("seq_data", bus.mem_wdata, 8'(8'h40 + issued));
                chk("seq_slot_phase", prev_phase, 1'b1);
                issued++;
            end
            if (s_wv && m_ready) idx++;
            prev_phase = s_phase;
        end
        chk("seq_count", issued, 5);

        // off-screen write is dropped, the following one lands at address 0
        idle(2);
        s_wv = 1'b1; s_wrow = 9'd480; s_wcol = 10'd0; s_wcolor = 8'h77;
        tick();
        s_wrow = 9'd0; s_wcol = 10'd0; s_wcolor = 8'h5E;
        tick();
        s_wv = 1'b0;
        nwe = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.mem_we === 1'b1) begin
                nwe++;
                chk("drop_addr", bus.mem_addr, 19'd0);
                chk("drop_data", bus.mem_wdata, 8'h5E);
            end
        end
        chk("drop_count", nwe, 1);

        // reset with queued writes and a display read in flight
        idle(2);
        s_blank = 1'b0; s_phase = 1'b0; s_wv = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_wrow = 9'(5 + k); s_wcol = 10'(5 + k); s_wcolor = 8'(8'h90 + k);
            tick();
        end
        s_wv = 1'b0;
        tick();
        s_rst = 1'b0;
        tick();
        chk("mid_rst_we", bus.mem_we, 1'b0);
        chk("mid_rst_ready", bus.wr_ready, 1'b0);
        tick();
        s_rst = 1'b1; s_blank = 1'b1; s_phase = 1'b1;
        tick();
        chk("mid_rel_ready", bus.wr_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_we", bus.mem_we, 1'b0);
            chk("post_rst_pvalid", bus.pixel_valid, 1'b0);
        end

        // randomized traffic against the model
        pcnt = 0;
        for (int k = 0; k < 1500; k++) begin
            pcnt++;
            s_phase = 1'(pcnt & 1);
            if ($urandom_range(0, 39) == 0) s_blank = ~s_blank;
            s_rst    = ($urandom_range(0, 499) != 0);
            s_vrow   = 9'($urandom_range(0, 479));
            s_vcol   = 10'($urandom_range(0, 639));
            s_wv     = ($urandom_range(0, 2) != 0);
            s_wrow   = ($urandom_range(0, 15) == 0) ? 9'($urandom) : 9'($urandom_range(0, 479));
            s_wcol   = ($urandom_range(0, 15) == 0) ? 10'($urandom) : 10'($urandom_range(0, 639));
            s_wcolor = 8'($urandom);
            s_rdata  = 8'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
